// File: rtl/ram_ctrl_pkg.sv
// Shared types and parameter defaults for the RAM access controller.
package ram_ctrl_pkg;

    localparam int ADDR_W_DEF      = 6;
    localparam int DATA_W_DEF      = 8;
    localparam int WAIT_CYCLES_DEF = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/ram_wait_timer.sv
// 4-bit loadable down-counter; done flags the last strobe-active cycle.
module ram_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [3:0] load_val_i,
    output logic       done_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/ram_access_ctrl.sv
// Async-SRAM access sequencer: SETUP / ACCESS / HOLD per beat, bursts with
// wrapping address; every output comes straight from a flop.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        len,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] adrs,
    output logic [DATA_W-1:0] dataIn,
    input  logic [DATA_W-1:0] dataOut,
    output logic              _ce,
    output logic              _we,
    output logic              _oe
);

    state_e              state_q, state_d;
    logic                wr_q;
    logic [3:0]          beats_q;
    logic [ADDR_W-1:0]   adrs_q;
    logic [DATA_W-1:0]   din_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ce_q, we_q, oe_q, ack_q, ready_q;
    logic                accept;
    logic                wr_next;
    logic                timer_done;

    ram_wait_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == SETUP),
        .en_i       (state_q == ACCESS),
        .load_val_i (4'(WAIT_CYCLES)),
        .done_o     (timer_done)
    );

    assign accept  = (state_q == IDLE) && req;
    // On the accept edge wr_q is not yet loaded, so use the live request type.
    assign wr_next = accept ? wr : wr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (timer_done) state_d = HOLD;
            HOLD:    state_d = (beats_q != 4'd0) ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ce_q    <= 1'b1;
            we_q    <= 1'b1;
            oe_q    <= 1'b1;
            ack_q   <= 1'b0;
            ready_q <= 1'b1;
            wr_q    <= 1'b0;
            beats_q <= 4'd0;
            adrs_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ce_q    <= (state_d == IDLE);
            we_q    <= !((state_d == ACCESS) && wr_q);
            oe_q    <= !((state_d == ACCESS) && !wr_q);
            ack_q   <= (state_d == HOLD);
            ready_q <= (state_d == IDLE);

            if (accept) begin
                wr_q    <= wr;
                beats_q <= len;
                adrs_q  <= addr;
            end
            if (state_q == HOLD && beats_q != 4'd0) begin
                beats_q <= beats_q - 4'd1;
                adrs_q  <= adrs_q + ADDR_W'(1);
            end
            if (state_d == SETUP && wr_next) begin
                din_q <= wdata;
            end
            if (state_q == ACCESS && timer_done && !wr_q) begin
                rdata_q <= dataOut;
            end
        end
    end

    assign ready  = ready_q;
    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign adrs   = adrs_q;
    assign dataIn = din_q;
    assign _ce    = ce_q;
    assign _we    = we_q;
    assign _oe    = oe_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench: instance 0 runs WAIT_CYCLES=1, instance 1 runs WAIT_CYCLES=2.
module tb_ram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_s   [2];
    logic       wr_s    [2];
    logic [5:0] addr_s  [2];
    logic [3:0] len_s   [2];
    logic [7:0] wdata_s [2];
    logic [7:0] dout_s  [2];
    logic       ready_s [2];
    logic       ack_s   [2];
    logic       ce_s    [2];
    logic       we_s    [2];
    logic       oe_s    [2];
    logic [7:0] rdata_s [2];
    logic [7:0] din_s   [2];
    logic [5:0] adrs_s  [2];
    logic [7:0] mem     [0:1][0:63];

    logic       rec_ack [0:31];
    logic       rec_ce  [0:31];
    logic       rec_we  [0:31];
    logic       rec_oe  [0:31];
    logic       rec_rdy [0:31];
    logic [5:0] rec_adr [0:31];
    logic [7:0] rec_din [0:31];
    logic [7:0] rec_rd  [0:31];

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.WAIT_CYCLES(1), .ADDR_W(6), .DATA_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .req(req_s[0]), .wr(wr_s[0]), .addr(addr_s[0]),
        .len(len_s[0]), .wdata(wdata_s[0]), .ready(ready_s[0]), .ack(ack_s[0]),
        .rdata(rdata_s[0]), .adrs(adrs_s[0]), .dataIn(din_s[0]), .dataOut(dout_s[0]),
        ._ce(ce_s[0]), ._we(we_s[0]), ._oe(oe_s[0])
    );

    ram_access_ctrl #(.WAIT_CYCLES(2), .ADDR_W(6), .DATA_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_s[1]), .wr(wr_s[1]), .addr(addr_s[1]),
        .len(len_s[1]), .wdata(wdata_s[1]), .ready(ready_s[1]), .ack(ack_s[1]),
        .rdata(rdata_s[1]), .adrs(adrs_s[1]), .dataIn(din_s[1]), .dataOut(dout_s[1]),
        ._ce(ce_s[1]), ._we(we_s[1]), ._oe(oe_s[1])
    );

    // RAM models: drive data only while _oe is low, write on edges with _we low.
    assign dout_s[0] = !oe_s[0] ? mem[0][adrs_s[0]] : 8'h00;
    assign dout_s[1] = !oe_s[1] ? mem[1][adrs_s[1]] : 8'h00;

    always @(posedge clk) begin
        if (!ce_s[0] && !we_s[0]) mem[0][adrs_s[0]] <= din_s[0];
        if (!ce_s[1] && !we_s[1]) mem[1][adrs_s[1]] <= din_s[1];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Protocol watch on both instances, sampled mid-cycle.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic       prev_low = 1'b0;
        logic [5:0] prev_adr;
        logic [7:0] prev_din;
        always @(negedge clk) begin
            if (!rst) begin
                chk("we_oe_excl", {31'b0, we_s[g] | oe_s[g]}, 32'd1);
                if ((!we_s[g] || !oe_s[g]) && prev_low) begin
                    chk("adrs_stable", {26'b0, adrs_s[g]}, {26'b0, prev_adr});
                    chk("din_stable", {24'b0, din_s[g]}, {24'b0, prev_din});
                end
            end
            prev_low = !we_s[g] || !oe_s[g];
            prev_adr = adrs_s[g];
            prev_din = din_s[g];
        end
    end

    function automatic int cnt(input int sel, input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) begin
            case (sel)
                0:       if (rec_ack[k])  n++;
                1:       if (!rec_we[k])  n++;
                2:       if (!rec_oe[k])  n++;
                default: if (!rec_ce[k])  n++;
            endcase
        end
        return n;
    endfunction

    task automatic start(input int d, input logic w, input logic [5:0] a,
                         input logic [3:0] l, input logic [7:0] wd);
        int waitc = 0;
        @(negedge clk);
        while (!ready_s[d] && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("ready_before_req", {31'b0, ready_s[d]}, 32'd1);
        wr_s[d] = w; addr_s[d] = a; len_s[d] = l; wdata_s[d] = wd; req_s[d] = 1'b1;
    endtask

    // Cycle k=1 is the cycle right after the accept edge.
    task automatic record(input int d, input int ncyc, input logic hold, input logic [7:0] wd);
        int per = (d == 0) ? 3 : 4;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (!hold) req_s[d] = 1'b0;
            rec_ack[k] = ack_s[d];  rec_ce[k]  = ce_s[d];   rec_we[k]  = we_s[d];
            rec_oe[k]  = oe_s[d];   rec_rdy[k] = ready_s[d]; rec_adr[k] = adrs_s[d];
            rec_din[k] = din_s[d];  rec_rd[k]  = rdata_s[d];
            wdata_s[d] = wd + 8'(k / per);
        end
        req_s[d] = 1'b0;
    endtask

    initial begin
        int waitc;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = '0; len_s[d] = '0; wdata_s[d] = '0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", {31'b0, ready_s[d]}, 32'd1);
            chk("rst_ack",   {31'b0, ack_s[d]},   32'd0);
            chk("rst_strb",  {29'b0, ce_s[d], we_s[d], oe_s[d]}, 32'h7);
            chk("rst_adrs",  {26'b0, adrs_s[d]},  32'd0);
            chk("rst_din",   {24'b0, din_s[d]},   32'd0);
            chk("rst_rdata", {24'b0, rdata_s[d]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Single write, W=1: addr 5 <- A5
        start(0, 1'b1, 6'd5, 4'd0, 8'hA5);
        record(0, 5, 1'b0, 8'hA5);
        chk("w1_we_low_cnt", cnt(1, 1, 5), 32'd1);
        chk("w1_we_at_2",    {31'b0, rec_we[2]}, 32'd0);
        chk("w1_adrs",       {26'b0, rec_adr[2]}, 32'd5);
        chk("w1_din",        {24'b0, rec_din[2]}, 32'hA5);
        chk("w1_oe_low_cnt", cnt(2, 1, 5), 32'd0);
        chk("w1_ack_at_3",   {31'b0, rec_ack[3]}, 32'd1);
        chk("w1_ack_cnt",    cnt(0, 1, 5), 32'd1);
        chk("w1_busy_3",     {31'b0, rec_rdy[3]}, 32'd0);
        chk("w1_ready_4",    {31'b0, rec_rdy[4]}, 32'd1);
        chk("w1_idle_hold",  {18'b0, rec_adr[5], rec_din[5]}, {18'b0, 6'd5, 8'hA5});
        chk("w1_mem",        {24'b0, mem[0][5]}, 32'hA5);

        // Single read, W=1: addr 5 -> A5
        start(0, 1'b0, 6'd5, 4'd0, 8'h00);
        record(0, 5, 1'b0, 8'h00);
        chk("r1_oe_low_cnt", cnt(2, 1, 5), 32'd1);
        chk("r1_oe_at_2",    {31'b0, rec_oe[2]}, 32'd0);
        chk("r1_we_low_cnt", cnt(1, 1, 5), 32'd0);
        chk("r1_ack_at_3",   {31'b0, rec_ack[3]}, 32'd1);
        chk("r1_rdata",      {24'b0, rec_rd[3]}, 32'hA5);
        chk("r1_rdata_held", {24'b0, rec_rd[5]}, 32'hA5);

        // Burst write, W=2: addr 62, 4 beats, data A0..A3, wraps 63 -> 0
        start(1, 1'b1, 6'd62, 4'd3, 8'hA0);
        record(1, 18, 1'b0, 8'hA0);
        chk("bw_adr_b0", {26'b0, rec_adr[2]},  32'd62);
        chk("bw_adr_b1", {26'b0, rec_adr[6]},  32'd63);
        chk("bw_adr_b2", {26'b0, rec_adr[10]}, 32'd0);
        chk("bw_adr_b3", {26'b0, rec_adr[14]}, 32'd1);
        chk("bw_din_b3", {24'b0, rec_din[14]}, 32'hA3);
        chk("bw_ack_4",  {31'b0, rec_ack[4]},  32'd1);
        chk("bw_ack_8",  {31'b0, rec_ack[8]},  32'd1);
        chk("bw_ack_12", {31'b0, rec_ack[12]}, 32'd1);
        chk("bw_ack_16", {31'b0, rec_ack[16]}, 32'd1);
        chk("bw_ack_cnt", cnt(0, 1, 18), 32'd4);
        chk("bw_we_low_cnt", cnt(1, 1, 18), 32'd8);
        chk("bw_busy_16", {31'b0, rec_rdy[16]}, 32'd0);
        chk("bw_ready_17", {31'b0, rec_rdy[17]}, 32'd1);
        chk("bw_mem", {mem[1][62], mem[1][63], mem[1][0], mem[1][1]}, 32'hA0A1A2A3);

        // Reset during ACCESS of the second beat of a W=2 burst write
        start(1, 1'b1, 6'd10, 4'd3, 8'hB0);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req_s[1] = 1'b0;
            rec_ack[k] = ack_s[1];
        end
        chk("rb_in_access", {31'b0, we_s[1]}, 32'd0);
        chk("rb_ack_pre",   cnt(0, 1, 6), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rb_strb",  {29'b0, ce_s[1], we_s[1], oe_s[1]}, 32'h7);
        chk("rb_ack",   {31'b0, ack_s[1]},   32'd0);
        chk("rb_ready", {31'b0, ready_s[1]}, 32'd1);
        chk("rb_adrs",  {26'b0, adrs_s[1]},  32'd0);
        chk("rb_din",   {24'b0, din_s[1]},   32'd0);
        #1;
        rst = 1'b0;
        wr_s[1] = 1'b0; addr_s[1] = 6'd62; len_s[1] = 4'd0; req_s[1] = 1'b1;
        record(1, 6, 1'b0, 8'h00);
        chk("ra_accept_first", {31'b0, rec_ce[1]}, 32'd0);
        chk("ra_no_stale_ack", cnt(0, 1, 3), 32'd0);
        chk("ra_oe_low_cnt",   cnt(2, 1, 6), 32'd2);
        chk("ra_ack_4",        {31'b0, rec_ack[4]}, 32'd1);
        chk("ra_rdata",        {24'b0, rec_rd[4]}, 32'hA0);
        chk("ra_ready_5",      {31'b0, rec_rdy[5]}, 32'd1);

        // req held high through a 2-beat read burst at addr 20
        start(1, 1'b0, 6'd20, 4'd1, 8'h00);
        record(1, 10, 1'b1, 8'h00);
        chk("rh_ack_cnt",   cnt(0, 1, 9), 32'd2);
        chk("rh_ack_8",     {31'b0, rec_ack[8]}, 32'd1);
        chk("rh_ce_low",    cnt(3, 1, 9), 32'd8);
        chk("rh_adr_b1",    {26'b0, rec_adr[6]}, 32'd21);
        chk("rh_idle_9",    {30'b0, rec_rdy[9], rec_ce[9]}, 32'h3);
        chk("rh_accept_10", {30'b0, rec_rdy[10], rec_ce[10]}, 32'h0);
        chk("rh_adr_10",    {26'b0, rec_adr[10]}, 32'd20);

        waitc = 0;
        while (!ready_s[1] && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("final_ready", {31'b0, ready_s[1]}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
